line_edit_buffer: RTL



---
 rtl/line_edit_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/line_edit_buffer.sv
// Single-line text editor fed by one-cycle ASCII pulses: printable chars, backspace and enter,
// with a ready/ack handoff of the finished line followed by a cell-by-cell clear.
module line_edit_buffer #(
  parameter int LINE_LEN = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   length,
  output logic              line_ready,
  input  logic              line_ack,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    HOLD  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(LINE_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_LEN - 1);

  state_t            state;
  state_t            next_state;
  logic [7:0]        cells [LINE_LEN];
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] bs_idx;
  logic              is_printable;
  logic              is_backspace;
  logic              is_enter;

  assign is_printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
  assign is_backspace = (char_in == 8'h08);
  assign is_enter     = (char_in == 8'h0D);
  assign wr_idx       = length[ADDR_W-1:0];
  // Wraps correctly when length == 2**ADDR_W: low bits are zero, so minus one lands on the last cell.
  assign bs_idx       = length[ADDR_W-1:0] - ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EDIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      EDIT:    if (char_valid && is_enter) next_state = HOLD;
      HOLD:    if (line_ack) next_state = CLEAR;
      CLEAR:   if (clr_idx == LAST_IDX) next_state = EDIT;
      default: next_state = EDIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_LEN; i++) begin
        cells[i] <= 8'h00;
      end
      length   <= '0;
      overflow <= 1'b0;
      clr_idx  <= '0;
    end else begin
      case (state)
        EDIT: begin
          if (char_valid) begin
            if (is_printable) begin
              if (length < LEN_MAX) begin
                cells[wr_idx] <= char_in;
                length        <= length + (ADDR_W+1)'(1);
              end else begin
                overflow <= 1'b1;
              end
            end else if (is_backspace && (length != '0)) begin
              cells[bs_idx] <= 8'h00;
              length        <= length - (ADDR_W+1)'(1);
            end
          end
        end
        HOLD: begin
          if (line_ack) begin
            length  <= '0;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          cells[clr_idx] <= 8'h00;
          clr_idx        <= clr_idx + ADDR_W'(1);
          if (clr_idx == LAST_IDX) begin
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign line_ready = (state == HOLD);
  assign busy       = (state != EDIT);
  assign rd_data    = ({1'b0, rd_addr} < LEN_MAX) ? cells[rd_addr] : 8'h00;

endmodule
